io_unit: RTL and testbench

- Responder for the CPU's IN/OUT instructions. The control unit drives OpIO (01 = IN, 10 = OUT); this block answers those requests.
- IN: stalls the CPU until the user presses Enter, then delivers the switch value to the register-file write path.
- OUT: latches a register value into a display register that drives the 7-segment/LED output logic.
- Sits between the datapath (regfile, PC-enable) and board I/O (switches, pushbutton, display).

---
 rtl/io_unit.sv | 129 ++++++++++++
 tb/tb_io_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/io_unit.sv
// rtl/io_unit.sv - IN/OUT responder: debounced Enter handshake for IN, display latch for OUT.
module io_unit #(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        OpIO,
  input  logic [DATA_W-1:0] outData,
  input  logic [SW_W-1:0]   switches,
  input  logic              enterBtn,
  output logic [DATA_W-1:0] inData,
  output logic              inValid,
  output logic              stall,
  output logic [DATA_W-1:0] display,
  output logic              outValid,
  output logic              waiting
);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, CAPTURE, WAIT_RELEASE} state_t;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t            state_q;
  logic              sync1_q, sync2_q;
  logic              stable_q, stable_d;
  logic              press_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] in_data_q, display_q;
  logic              in_valid_q, out_valid_q, waiting_q;
  logic              op_in, op_out;

  assign op_in  = (OpIO == 2'b01);
  assign op_out = (OpIO == 2'b10);

  // Gated by reset so the CPU is never held while the block itself is in reset.
  assign stall = reset & ((state_q == IDLE && op_in) ||
                          (state_q == WAIT_PRESS) ||
                          (state_q == WAIT_RELEASE && op_in));

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= enterBtn;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= stable_d & ~stable_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      waiting_q  <= 1'b0;
    end else begin
      in_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (op_in) begin
            state_q   <= WAIT_PRESS;
            waiting_q <= 1'b1;
          end
        end
        WAIT_PRESS: begin
          if (press_q) begin
            in_data_q  <= DATA_W'(switches);
            in_valid_q <= 1'b1;
            waiting_q  <= 1'b0;
            state_q    <= CAPTURE;
          end
        end
        CAPTURE: state_q <= WAIT_RELEASE;
        WAIT_RELEASE: begin
          // A still-held button must be released before another IN can be served.
          if (!stable_q) begin
            if (op_in) begin
              state_q   <= WAIT_PRESS;
              waiting_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      display_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= op_out & ~stall;
      if (op_out && !stall) begin
        display_q <= outData;
      end
    end
  end

  assign inData   = in_data_q;
  assign inValid  = in_valid_q;
  assign display  = display_q;
  assign outValid = out_valid_q;
  assign waiting  = waiting_q;

endmodule

// File: tb/tb_io_unit.sv
// tb/tb_io_unit.sv - directed self-checking bench for io_unit.
module tb_io_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  OpIO = 2'b00;
  logic [31:0] outData = '0;
  logic [15:0] switches = '0;
  logic        enterBtn = 1'b0;
  logic [31:0] inData;
  logic        inValid;
  logic        stall;
  logic [31:0] display;
  logic        outValid;
  logic        waiting;

  int checks = 0;
  int failures = 0;

  io_unit #(.DATA_W(32), .SW_W(16), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .OpIO(OpIO), .outData(outData),
    .switches(switches), .enterBtn(enterBtn), .inData(inData),
    .inValid(inValid), .stall(stall), .display(display),
    .outValid(outValid), .waiting(waiting)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b0; OpIO = 2'b01;
    step(); step();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (waiting !== 1'b0) begin failures++; $display("FAIL reset_waiting got=%b exp=0", waiting); end
    checks++; if (inValid !== 1'b0 || outValid !== 1'b0) begin failures++; $display("FAIL reset_valids got=%b%b exp=00", inValid, outValid); end
    checks++; if (inData !== 32'h0 || display !== 32'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", inData, display); end
    reset = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL release_stall got=%b exp=1", stall); end
    checks++; if (waiting !== 1'b0) begin failures++; $display("FAIL release_waiting got=%b exp=0", waiting); end
    step();
    checks++; if (waiting !== 1'b1) begin failures++; $display("FAIL wait_after_release got=%b exp=1", waiting); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (stall !== 1'b1 || inValid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_hold_100 bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_in_handshake();
    int got;
    int bad;
    switches = 16'hA5C3;
    enterBtn = 1'b1;
    got = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (inValid === 1'b1) begin got = i; break; end
    end
    // Button is first sampled at the edge after it is driven; capture follows six cycles later.
    checks++; if (got != 7) begin failures++; $display("FAIL in_latency got=%0d exp=7", got); end
    checks++; if (inData !== 32'h0000A5C3) begin failures++; $display("FAIL in_data got=%h exp=0000a5c3", inData); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL capture_stall got=%b exp=0", stall); end
    checks++; if (waiting !== 1'b0) begin failures++; $display("FAIL capture_waiting got=%b exp=0", waiting); end
    OpIO = 2'b00;
    step();
    checks++; if (inValid !== 1'b0) begin failures++; $display("FAIL in_valid_pulse got=%b exp=0", inValid); end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (stall !== 1'b0 || inValid !== 1'b0) bad++;
    end
    enterBtn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (stall !== 1'b0 || inValid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL post_capture_quiet bad_cycles=%0d exp=0", bad); end
    checks++; if (inData !== 32'h0000A5C3) begin failures++; $display("FAIL in_data_hold got=%h exp=0000a5c3", inData); end
    OpIO = 2'b01;
    step();
    checks++; if (waiting !== 1'b1) begin failures++; $display("FAIL back_to_idle_then_in got=%b exp=1", waiting); end
  endtask

  task automatic test_back_to_back();
    int got;
    int pulses;
    int bad;
    switches = 16'h1111;
    enterBtn = 1'b1;
    got = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (inValid === 1'b1) begin got = i; break; end
    end
    checks++; if (got == 0 || inData !== 32'h00001111) begin failures++; $display("FAIL b2b_first got_cycle=%0d data=%h exp=00001111", got, inData); end
    switches = 16'h0007;
    pulses = 0; bad = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (inValid === 1'b1) pulses++;
      if (stall !== 1'b1) bad++;
    end
    enterBtn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (inValid === 1'b1) pulses++;
      if (stall !== 1'b1) bad++;
    end
    checks++; if (pulses != 0 || bad != 0) begin failures++; $display("FAIL held_button pulses=%0d unstalled=%0d exp=0/0", pulses, bad); end
    enterBtn = 1'b1;
    got = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (inValid === 1'b1) begin got = i; break; end
    end
    checks++; if (got != 7) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=7", got); end
    checks++; if (inData !== 32'h00000007) begin failures++; $display("FAIL b2b_second_data got=%h exp=00000007", inData); end
    OpIO = 2'b00;
    step();
    enterBtn = 1'b0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_bounce();
    int pulses;
    int bad;
    OpIO = 2'b01;
    pulses = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) enterBtn = ~enterBtn;
      step();
      if (inValid === 1'b1) pulses++;
    end
    enterBtn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (inValid === 1'b1) pulses++;
      if (stall !== 1'b1) bad++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL bounce_pulses got=%0d exp=0", pulses); end
    checks++; if (bad != 0 || waiting !== 1'b1) begin failures++; $display("FAIL bounce_still_waiting unstalled=%0d waiting=%b exp=0/1", bad, waiting); end
  endtask

  task automatic test_reset_mid_wait();
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || waiting !== 1'b0) begin failures++; $display("FAIL midwait_reset stall=%b waiting=%b exp=0/0", stall, waiting); end
    checks++; if (display !== 32'h0 || inData !== 32'h0) begin failures++; $display("FAIL midwait_reset_data got=%h/%h exp=0/0", display, inData); end
    step();
    OpIO = 2'b00;
    reset = 1'b1;
    step(); step();
    checks++; if (stall !== 1'b0 || waiting !== 1'b0 || inData !== 32'h0) begin failures++; $display("FAIL midwait_after stall=%b waiting=%b data=%h exp=0/0/0", stall, waiting, inData); end
  endtask

  task automatic test_out();
    int bad;
    bad = 0;
    OpIO = 2'b10; outData = 32'hDEADBEEF;
    #1; if (stall !== 1'b0) bad++;
    step();
    checks++; if (display !== 32'hDEADBEEF || outValid !== 1'b1) begin failures++; $display("FAIL out_single display=%h valid=%b exp=deadbeef/1", display, outValid); end
    OpIO = 2'b00; outData = 32'h12345678;
    step();
    checks++; if (outValid !== 1'b0 || display !== 32'hDEADBEEF) begin failures++; $display("FAIL out_pulse_end valid=%b display=%h exp=0/deadbeef", outValid, display); end
    OpIO = 2'b11;
    step();
    checks++; if (outValid !== 1'b0 || display !== 32'hDEADBEEF || stall !== 1'b0) begin failures++; $display("FAIL op11_noop valid=%b display=%h stall=%b", outValid, display, stall); end
    OpIO = 2'b10; outData = 32'd1;
    #1; if (stall !== 1'b0) bad++;
    step();
    checks++; if (display !== 32'd1 || outValid !== 1'b1) begin failures++; $display("FAIL out_first display=%h valid=%b exp=1/1", display, outValid); end
    outData = 32'd2;
    #1; if (stall !== 1'b0) bad++;
    step();
    checks++; if (display !== 32'd2 || outValid !== 1'b1) begin failures++; $display("FAIL out_second display=%h valid=%b exp=2/1", display, outValid); end
    OpIO = 2'b00;
    step();
    checks++; if (outValid !== 1'b0 || display !== 32'd2) begin failures++; $display("FAIL out_end valid=%b display=%h exp=0/2", outValid, display); end
    checks++; if (bad != 0) begin failures++; $display("FAIL out_stall got=%0d exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_in_handshake();
    test_back_to_back();
    test_bounce();
    test_reset_mid_wait();
    test_out();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
